// File: rtl/signal_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : signal_debouncer
// Description : Synchronises a raw asynchronous level and only lets o_signal
//               follow it after p_STABLE_CYCLES consecutive differing clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module signal_debouncer #(
  parameter int p_SYNC_STAGES   = 2,
  parameter int p_STABLE_CYCLES = 4,
  parameter bit p_RESET_VALUE   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_signal,
  output logic o_signal,
  output logic o_busy
);

  localparam int                 c_CNT_W    = $clog2(p_STABLE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(p_STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  logic [p_SYNC_STAGES-1:0] r_sync;
  logic [c_CNT_W-1:0]       r_cnt;
  state_t                   r_state;
  logic                     r_signal;
  logic                     w_sync;

  // Plain shift chain: nothing may sit between stages or metastability leaks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {p_SYNC_STAGES{p_RESET_VALUE}};
    end else begin
      r_sync <= {r_sync[p_SYNC_STAGES-2:0], i_signal};
    end
  end

  assign w_sync = r_sync[p_SYNC_STAGES-1];

  // Any revert to the current output level aborts qualification, so a new
  // candidate always restarts its window from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_state  <= ST_IDLE;
      r_signal <= p_RESET_VALUE;
    end else if (w_sync == r_signal) begin
      r_cnt    <= '0;
      r_state  <= ST_IDLE;
    end else if (r_cnt == c_CNT_LAST) begin
      r_signal <= w_sync;
      r_cnt    <= '0;
      r_state  <= ST_IDLE;
    end else begin
      r_cnt    <= r_cnt + c_CNT_ONE;
      r_state  <= ST_SETTLING;
    end
  end

  assign o_signal = r_signal;
  assign o_busy   = (r_state == ST_SETTLING);

endmodule
`default_nettype wire
